// File: rtl/wb_pkg.sv
// Shared types for the round-robin Wishbone arbiter.
// Also supplies default ADDR_WIDTH / DATA_WIDTH when the build does not define them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package wb_pkg;

  typedef enum logic {
    WB_ARB_IDLE = 1'b0,
    WB_ARB_BUSY = 1'b1
  } wb_arb_state_t;

  function automatic int wb_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_i,
// wrapping modulo N, so last_i itself is chosen only when it is the sole requester.
module wb_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the farthest candidate back to the nearest so the nearest hit wins.
  always_comb begin : p_scan
    int          j;
    logic [IW-1:0] sel;
    j       = 0;
    sel     = '0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N; k >= 1; k--) begin
      j   = (int'(last_i) + k) % N;
      sel = IW'(j);
      if (req_i[sel]) begin
        valid_o = 1'b1;
        idx_o   = sel;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one classic-cycle Wishbone slave between NUM_MASTERS.
// Optional watchdog (ack timeout with m_err_o) enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_MASTERS-1:0]             m_cyc_i,
  input  logic [NUM_MASTERS-1:0]             m_stb_i,
  input  logic [NUM_MASTERS-1:0]             m_we_i,
  input  logic [NUM_MASTERS*`ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*`DATA_WIDTH-1:0] m_dat_i,
  output logic [`DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]             m_ack_o,
`ifdef WB_ARB_TIMEOUT_EN
  output logic [NUM_MASTERS-1:0]             m_err_o,
`endif
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  output logic                               s_we_o,
  output logic [`ADDR_WIDTH-1:0]             s_adr_o,
  output logic [`DATA_WIDTH-1:0]             s_dat_o,
  input  logic [`DATA_WIDTH-1:0]             s_dat_i,
  input  logic                               s_ack_i,
  output logic [NUM_MASTERS-1:0]             grant_o
);

  localparam int IW = wb_idx_width(NUM_MASTERS);
  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  wb_arb_state_t          state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   busy;
  logic                   active;
  logic                   timeout;

  wb_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign busy    = (state_q == WB_ARB_BUSY);
  assign active  = busy && m_cyc_i[owner_q];
  assign grant_o = grant_q;

  // Slave side follows the owner only while it still holds cyc.
  always_comb begin
    s_cyc_o = active;
    s_stb_o = active && m_stb_i[owner_q];
    s_we_o  = active && m_we_i[owner_q];
    s_adr_o = active ? m_adr_i[int'(owner_q)*AW +: AW] : '0;
    s_dat_o = active ? m_dat_i[int'(owner_q)*DW +: DW] : '0;
    m_ack_o = '0;
    if (busy) m_ack_o[owner_q] = s_ack_i;
    m_dat_o = rst_i ? '0 : s_dat_i;
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout = busy && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (!busy || timeout || s_ack_i) cnt_d = '0;
    else if (s_stb_o)                cnt_d = cnt_q + 1'b1;
    m_err_o = '0;
    if (timeout) m_err_o[owner_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      WB_ARB_IDLE: begin
        if (pick_valid) begin
          state_d           = WB_ARB_BUSY;
          owner_d           = pick_idx;
          last_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      WB_ARB_BUSY: begin
        // Release and watchdog both pass through IDLE, forcing a gap between owners.
        if (timeout || !m_cyc_i[owner_q]) begin
          state_d = WB_ARB_IDLE;
          last_d  = owner_q;
          grant_d = '0;
        end
      end
      default: begin
        state_d = WB_ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WB_ARB_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner cases and a
// randomized run against an ownership-level reference model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_wb_arbiter;

  localparam int N  = 2;
  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int T  = 16;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o;
`ifdef WB_ARB_TIMEOUT_EN
  logic [N-1:0]    m_err_o;
`endif
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic            s_ack_i;
  logic [N-1:0]    grant_o;

  logic            slave_auto;
  logic            tb_ack;
  logic [DW-1:0]   tb_rdat;
  logic [DW-1:0]   mem [16];

  int tests_run    = 0;
  int tests_failed = 0;

  int r_owner;
  int r_last;
  int r_stall;

  typedef struct {
    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] dat0, dat1;
    logic          ack;
    logic [1:0]    exp_grant;
    logic          exp_scyc;
    logic [AW-1:0] exp_adr;
    logic [DW-1:0] exp_dat;
    logic [1:0]    exp_ack;
  } vec_t;

  vec_t vecs[12];

  always #5 clk_i = ~clk_i;

  wb_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
`ifdef WB_ARB_TIMEOUT_EN
    .m_err_o (m_err_o),
`endif
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .grant_o (grant_o)
  );

  // Tiny register-file slave that acks every strobe immediately.
  assign s_ack_i = slave_auto ? (s_cyc_o & s_stb_o) : tb_ack;
  assign s_dat_i = slave_auto ? mem[s_adr_o[3:0]] : tb_rdat;

  always @(posedge clk_i) begin
    if (slave_auto && s_cyc_o && s_stb_o && s_we_o) mem[s_adr_o[3:0]] <= s_dat_o;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    m_cyc_i            = v.cyc;
    m_stb_i            = v.stb;
    m_we_i             = v.we;
    m_adr_i[0*AW +: AW] = v.adr0;
    m_adr_i[1*AW +: AW] = v.adr1;
    m_dat_i[0*DW +: DW] = v.dat0;
    m_dat_i[1*DW +: DW] = v.dat1;
    tb_ack             = v.ack;
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i   = 1'b1;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    tb_ack  = 1'b0;
    @(negedge clk_i);
    rst_i   = 1'b0;
    r_owner = -1;
    r_last  = N - 1;
    r_stall = 0;
  endtask

  logic ack_other_seen;

  task automatic waitAck(input int m, output bit got);
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk_i);
      #1;
      if ((m_ack_o & ~(N'(1) << m)) != '0) ack_other_seen = 1'b1;
      if (m_ack_o[m]) got = 1'b1;
    end
  endtask

  // Reference model: ownership as an index (-1 when idle), round-robin from last+1.
  function automatic int pickNext(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic checkModel();
    logic [N-1:0]  e_grant, e_ack, e_err;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    e_grant = '0; e_ack = '0; e_err = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
    if (r_owner >= 0) begin
      e_grant[r_owner] = 1'b1;
      e_ack[r_owner]   = tb_ack;
      if (TO_EN && r_stall == T) e_err[r_owner] = 1'b1;
      if (m_cyc_i[r_owner]) begin
        e_cyc = 1'b1;
        e_stb = m_stb_i[r_owner];
        e_we  = m_we_i[r_owner];
        e_adr = m_adr_i[r_owner*AW +: AW];
        e_dat = m_dat_i[r_owner*DW +: DW];
      end
    end
    checkOutput("rand grant_o", grant_o, e_grant);
    checkOutput("rand s_cyc_o", s_cyc_o, e_cyc);
    checkOutput("rand s_stb_o", s_stb_o, e_stb);
    checkOutput("rand s_we_o", s_we_o, e_we);
    checkOutput("rand s_adr_o", s_adr_o, e_adr);
    checkOutput("rand s_dat_o", s_dat_o, e_dat);
    checkOutput("rand m_ack_o", m_ack_o, e_ack);
    checkOutput("rand m_dat_o", m_dat_o, tb_rdat);
`ifdef WB_ARB_TIMEOUT_EN
    checkOutput("rand m_err_o", m_err_o, e_err);
`endif
  endtask

  task automatic updateModel();
    int p;
    if (r_owner < 0) begin
      r_stall = 0;
      p = pickNext(m_cyc_i, r_last);
      if (p >= 0) begin
        r_owner = p;
        r_last  = p;
      end
    end else if (TO_EN && r_stall == T) begin
      r_owner = -1;
      r_stall = 0;
    end else if (!m_cyc_i[r_owner]) begin
      r_owner = -1;
      r_stall = 0;
    end else if (tb_ack) begin
      r_stall = 0;
    end else if (m_stb_i[r_owner]) begin
      r_stall++;
    end
  endtask

  initial begin
    bit got;
    vecs[0]  = '{2'b11, 2'b11, 2'b00, 8'h10, 8'h20, 8'hA1, 8'hB1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[1]  = '{2'b11, 2'b11, 2'b00, 8'h10, 8'h21, 8'hA1, 8'hB2, 1'b1, 2'b01, 1'b1, 8'h10, 8'hA1, 2'b01};
    vecs[2]  = '{2'b10, 2'b10, 2'b00, 8'h11, 8'h21, 8'hA1, 8'hB2, 1'b0, 2'b01, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[3]  = '{2'b11, 2'b11, 2'b00, 8'h11, 8'h21, 8'hA1, 8'hB2, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[4]  = '{2'b11, 2'b11, 2'b00, 8'h12, 8'h22, 8'hA2, 8'hB3, 1'b1, 2'b10, 1'b1, 8'h22, 8'hB3, 2'b10};
    vecs[5]  = '{2'b01, 2'b01, 2'b00, 8'h12, 8'h22, 8'hA2, 8'hB3, 1'b0, 2'b10, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[6]  = '{2'b01, 2'b01, 2'b00, 8'h12, 8'h22, 8'hA2, 8'hB3, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[7]  = '{2'b01, 2'b01, 2'b01, 8'h12, 8'h23, 8'hA2, 8'hB4, 1'b1, 2'b01, 1'b1, 8'h12, 8'hA2, 2'b01};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 8'h12, 8'h23, 8'hA2, 8'hB4, 1'b0, 2'b01, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 8'h12, 8'h23, 8'hA2, 8'hB4, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[10] = '{2'b01, 2'b01, 2'b00, 8'h12, 8'h23, 8'hA2, 8'hB4, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[11] = '{2'b01, 2'b01, 2'b00, 8'h13, 8'h24, 8'hA3, 8'hB5, 1'b0, 2'b01, 1'b1, 8'h13, 8'hA3, 2'b00};

    rst_i = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0;
    slave_auto = 1'b0; tb_ack = 1'b1; tb_rdat = 8'h5A;
    ack_other_seen = 1'b0;

    // Everything is held low during reset, even with the slave acking.
    @(negedge clk_i);
    #1;
    checkOutput("reset grant_o", grant_o, 0);
    checkOutput("reset s_cyc_o", s_cyc_o, 0);
    checkOutput("reset m_ack_o", m_ack_o, 0);
    checkOutput("reset m_dat_o", m_dat_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tb_ack = 1'b0;
    #1;
    checkOutput("post-reset m_dat_o broadcast", m_dat_o, 8'h5A);
    checkOutput("post-reset grant_o", grant_o, 0);

    // Contention, fairness, non-owner isolation and single-requester re-grant.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d grant_o", i), grant_o, vecs[i].exp_grant);
      checkOutput($sformatf("vec%0d s_cyc_o", i), s_cyc_o, vecs[i].exp_scyc);
      checkOutput($sformatf("vec%0d s_adr_o", i), s_adr_o, vecs[i].exp_adr);
      checkOutput($sformatf("vec%0d s_dat_o", i), s_dat_o, vecs[i].exp_dat);
      checkOutput($sformatf("vec%0d m_ack_o", i), m_ack_o, vecs[i].exp_ack);
    end

    // Single master: write 0x73 to address 0, then read it back.
    doReset();
    slave_auto = 1'b1;
    ack_other_seen = 1'b0;
    @(negedge clk_i);
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
    m_adr_i[0 +: AW] = '0; m_dat_i[0 +: DW] = 8'h73;
    waitAck(0, got);
    checkOutput("write ack seen", got, 1);
    checkOutput("write m_ack_o", m_ack_o, 2'b01);
    @(negedge clk_i);
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    @(negedge clk_i);
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    waitAck(0, got);
    checkOutput("read ack seen", got, 1);
    checkOutput("read m_ack_o", m_ack_o, 2'b01);
    checkOutput("read m_dat_o", m_dat_o, 8'h73);
    @(negedge clk_i);
    m_cyc_i = '0; m_stb_i = '0;
    checkOutput("master1 ack never high", ack_other_seen, 0);
    slave_auto = 1'b0;

    // Reset asserted mid-cycle while master 1 owns the bus with stb high.
    doReset();
    @(negedge clk_i);
    m_cyc_i = 2'b10; m_stb_i = 2'b10; tb_ack = 1'b1;
    m_adr_i[1*AW +: AW] = 8'h33; m_adr_i[0 +: AW] = 8'h44;
    @(negedge clk_i);
    #1;
    checkOutput("pre-reset grant_o", grant_o, 2'b10);
    checkOutput("pre-reset s_stb_o", s_stb_o, 1);
    checkOutput("pre-reset s_adr_o", s_adr_o, 8'h33);
    checkOutput("pre-reset m_ack_o", m_ack_o, 2'b10);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("mid-reset s_cyc_o", s_cyc_o, 0);
    checkOutput("mid-reset s_stb_o", s_stb_o, 0);
    checkOutput("mid-reset s_adr_o", s_adr_o, 0);
    checkOutput("mid-reset grant_o", grant_o, 0);
    checkOutput("mid-reset m_ack_o", m_ack_o, 0);
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    checkOutput("after-reset first grant", grant_o, 2'b01);
    checkOutput("after-reset s_adr_o", s_adr_o, 8'h44);
    tb_ack = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: slave never acks, err pulses once on the 17th stalled busy cycle.
    begin
      int busy_cycles;
      int err_at;
      logic [N-1:0] err_val;
      busy_cycles = 0; err_at = -1; err_val = '0;
      doReset();
      @(negedge clk_i);
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      for (int c = 0; c < 40 && err_at < 0; c++) begin
        @(negedge clk_i);
        #1;
        if (grant_o[0]) busy_cycles++;
        if (m_err_o != '0) begin
          err_at  = busy_cycles;
          err_val = m_err_o;
        end
      end
      checkOutput("timeout err cycle", err_at, T + 1);
      checkOutput("timeout err owner", err_val, 2'b01);
      @(negedge clk_i);
      #1;
      checkOutput("timeout err one cycle", m_err_o, 0);
      checkOutput("timeout back to idle", grant_o, 0);
    end
`endif

    // Randomized traffic against the ownership-level model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) m_cyc_i[b] = ~m_cyc_i[b];
      end
      m_stb_i = N'($urandom);
      m_we_i  = N'($urandom);
      m_adr_i = (N*AW)'({$urandom, $urandom});
      m_dat_i = (N*DW)'({$urandom, $urandom});
      tb_ack  = 1'($urandom_range(1));
      tb_rdat = DW'($urandom);
      #1;
      checkModel();
      @(posedge clk_i);
      updateModel();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
